// File: rtl/bcd_countdown_timer_pkg.sv
// bcd_countdown_timer_pkg
// Shared game types and constants for the countdown timer.
//   state_t   : timer FSM state (IDLE / RUN / DONE)
//   bcd_t     : one BCD digit
//   RST_*     : level-0 time budget (also the first entry of the level-time table)
//   bcd_clamp : saturates an out-of-range BCD digit to 9
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t RST_THREE = 4'd2;
  localparam bcd_t RST_TWO   = 4'd0;
  localparam bcd_t RST_ONE   = 4'd0;

  function automatic bcd_t bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if
// Control / display bundle between the game logic and the countdown timer.
//   master : game side, drives load/start/stop and the load digits
//   slave  : timer side, drives the remaining-time digits and status
// Optional macro TIMER_WARN_EN adds the warn signal.
interface bcd_countdown_timer_if;
  import bcd_countdown_timer_pkg::*;

  logic load;
  bcd_t load_three;
  bcd_t load_two;
  bcd_t load_one;
  logic start;
  logic stop;
  bcd_t digit_three;
  bcd_t digit_two;
  bcd_t digit_one;
  logic running;
  logic expired;
  logic time_up;
`ifdef TIMER_WARN_EN
  logic warn;
`endif

  modport master (
    output load, load_three, load_two, load_one, start, stop,
    input  digit_three, digit_two, digit_one, running, expired, time_up
`ifdef TIMER_WARN_EN
    , input warn
`endif
  );

  modport slave (
    input  load, load_three, load_two, load_one, start, stop,
    output digit_three, digit_two, digit_one, running, expired, time_up
`ifdef TIMER_WARN_EN
    , output warn
`endif
  );

endinterface

// File: rtl/bcd_countdown_timer_dec.sv
// bcd_digit_dec
// Single BCD digit decrementer with borrow chaining.
//   digit      : current digit
//   borrow_in  : decrement request from the lower digit
//   digit_next : digit after the optional decrement (0 wraps to 9)
//   borrow_out : propagated borrow when 0 wraps
module bcd_digit_dec
  import bcd_countdown_timer_pkg::*;
(
  input  bcd_t digit,
  input  logic borrow_in,
  output bcd_t digit_next,
  output logic borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = 4'd9;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
// Three-digit BCD countdown timer, one decrement per TICK_DIV clocks.
//   clk, reset   : clock, async active-low reset
//   bus (slave)  : load/start/stop controls, load digits, remaining-time
//                  digits, running, expired (1-cycle pulse), time_up (level)
// Optional macro TIMER_WARN_EN adds a registered low-time warning (WARN_SECS).
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int WARN_SECS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_countdown_timer_if.slave  bus
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t           r_state;
  bcd_t             r_d3, r_d2, r_d1;
  logic [PRE_W-1:0] r_pre;
  logic             r_running, r_expired, r_time_up;

  // Next-state values; the register block below only latches them.
  state_t           w_state;
  bcd_t             w_d3, w_d2, w_d1;
  logic [PRE_W-1:0] w_pre;
  logic             w_expired;

  logic w_tick;
  bcd_t w_dec3, w_dec2, w_dec1;
  logic w_b1, w_b2, w_b3;
  logic w_dec_zero;

  assign w_tick = (r_state == ST_RUN) && (r_pre == PRE_W'(TICK_DIV - 1));

  bcd_digit_dec u_dec_one   (.digit(r_d1), .borrow_in(1'b1), .digit_next(w_dec1), .borrow_out(w_b1));
  bcd_digit_dec u_dec_two   (.digit(r_d2), .borrow_in(w_b1), .digit_next(w_dec2), .borrow_out(w_b2));
  bcd_digit_dec u_dec_three (.digit(r_d3), .borrow_in(w_b2), .digit_next(w_dec3), .borrow_out(w_b3));

  // w_b3 only fires on an underflow of 000, which RUN never holds; treat it
  // as expiry anyway so the counter can never wrap to 999.
  assign w_dec_zero = ({w_dec3, w_dec2, w_dec1} == 12'h000) || w_b3;

  // Priority: load > stop > tick > start.
  always_comb begin
    w_state   = r_state;
    w_d3      = r_d3;
    w_d2      = r_d2;
    w_d1      = r_d1;
    w_pre     = r_pre;
    w_expired = 1'b0;
    if (bus.load) begin
      w_d3    = bcd_clamp(bus.load_three);
      w_d2    = bcd_clamp(bus.load_two);
      w_d1    = bcd_clamp(bus.load_one);
      w_pre   = '0;
      w_state = ST_IDLE;
    end else if (bus.stop && r_state == ST_RUN) begin
      w_pre   = '0;
      w_state = ST_IDLE;
    end else if (r_state == ST_RUN) begin
      if (w_tick) begin
        w_pre = '0;
        if (w_dec_zero) begin
          w_d3      = 4'd0;
          w_d2      = 4'd0;
          w_d1      = 4'd0;
          w_state   = ST_DONE;
          w_expired = 1'b1;
        end else begin
          w_d3 = w_dec3;
          w_d2 = w_dec2;
          w_d1 = w_dec1;
        end
      end else begin
        w_pre = r_pre + 1'b1;
      end
    end else if (bus.start && r_state == ST_IDLE) begin
      w_pre = '0;
      if ({r_d3, r_d2, r_d1} == 12'h000) begin
        w_state   = ST_DONE;
        w_expired = 1'b1;
      end else begin
        w_state = ST_RUN;
      end
    end
  end

`ifdef TIMER_WARN_EN
  logic       r_warn;
  logic [6:0] w_two_val;
  logic       w_warn;
  assign w_two_val = ({3'b0, w_d2} * 7'd10) + {3'b0, w_d1};
  assign w_warn    = (w_state == ST_RUN) && (w_d3 == 4'd0) &&
                     ({25'd0, w_two_val} <= WARN_SECS);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_warn <= 1'b0;
    else        r_warn <= w_warn;
  end
  assign bus.warn = r_warn;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_d3      <= RST_THREE;
      r_d2      <= RST_TWO;
      r_d1      <= RST_ONE;
      r_pre     <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_time_up <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_d3      <= w_d3;
      r_d2      <= w_d2;
      r_d1      <= w_d1;
      r_pre     <= w_pre;
      r_running <= (w_state == ST_RUN);
      r_expired <= w_expired;
      r_time_up <= (w_state == ST_DONE);
    end
  end

  assign bus.digit_three = r_d3;
  assign bus.digit_two   = r_d2;
  assign bus.digit_one   = r_d1;
  assign bus.running     = r_running;
  assign bus.expired     = r_expired;
  assign bus.time_up     = r_time_up;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer
// Directed bench for bcd_countdown_timer with TICK_DIV=4. Inputs change on
// the falling edge; outputs are sampled on the falling edge.
module tb_bcd_countdown_timer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  bcd_countdown_timer_if tif();

  bcd_countdown_timer #(.TICK_DIV(4), .WARN_SECS(10)) dut (
    .clk(clk), .reset(reset), .bus(tif)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] digs();
    return {tif.digit_three, tif.digit_two, tif.digit_one};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_load(input logic [3:0] h, t, u, input logic with_start);
    tif.load_three = h; tif.load_two = t; tif.load_one = u;
    tif.load = 1'b1; tif.start = with_start;
    @(negedge clk);
    tif.load = 1'b0; tif.start = 1'b0;
  endtask

  task automatic pulse_start();
    tif.start = 1'b1; @(negedge clk); tif.start = 1'b0;
  endtask

  task automatic pulse_stop();
    tif.stop = 1'b1; @(negedge clk); tif.stop = 1'b0;
  endtask

  task automatic test_reset();
    wait_cyc(2);
    total++; if (digs() !== 12'h200) begin bad++; $display("FAIL reset_digits got=%h want=200", digs()); end
    total++; if (tif.running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", tif.running); end
    total++; if (tif.time_up !== 1'b0 || tif.expired !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", tif.time_up, tif.expired); end
    reset = 1'b1;
    wait_cyc(2);
    total++; if (digs() !== 12'h200 || tif.running !== 1'b0) begin bad++; $display("FAIL release_state got=%h/%b want=200/0", digs(), tif.running); end
  endtask

  task automatic test_count();
    drive_load(4'd0, 4'd1, 4'd5, 1'b0);
    total++; if (digs() !== 12'h015) begin bad++; $display("FAIL load_015 got=%h want=015", digs()); end
    pulse_start();
    total++; if (tif.running !== 1'b1) begin bad++; $display("FAIL start_running got=%b want=1", tif.running); end
    wait_cyc(3);
    total++; if (digs() !== 12'h015) begin bad++; $display("FAIL pre_tick got=%h want=015", digs()); end
    wait_cyc(1);
    total++; if (digs() !== 12'h014) begin bad++; $display("FAIL first_tick got=%h want=014", digs()); end
    wait_cyc(4);
    total++; if (digs() !== 12'h013) begin bad++; $display("FAIL second_tick got=%h want=013", digs()); end
  endtask

  task automatic test_borrow();
    drive_load(4'd1, 4'd0, 4'd0, 1'b0);
    pulse_start();
    wait_cyc(4);
    total++; if (digs() !== 12'h099) begin bad++; $display("FAIL borrow_100 got=%h want=099", digs()); end
    drive_load(4'd0, 4'd1, 4'd0, 1'b0);
    pulse_start();
    wait_cyc(4);
    total++; if (digs() !== 12'h009) begin bad++; $display("FAIL borrow_010 got=%h want=009", digs()); end
  endtask

  task automatic test_expire();
    drive_load(4'd0, 4'd0, 4'd2, 1'b0);
    pulse_start();
    wait_cyc(4);
    total++; if (digs() !== 12'h001 || tif.expired !== 1'b0) begin bad++; $display("FAIL exp_001 got=%h/%b want=001/0", digs(), tif.expired); end
    wait_cyc(4);
    total++; if (digs() !== 12'h000) begin bad++; $display("FAIL exp_000 got=%h want=000", digs()); end
    total++; if (tif.expired !== 1'b1 || tif.time_up !== 1'b1 || tif.running !== 1'b0) begin bad++; $display("FAIL exp_pulse got=e%b t%b r%b want=e1 t1 r0", tif.expired, tif.time_up, tif.running); end
    wait_cyc(1);
    total++; if (tif.expired !== 1'b0 || tif.time_up !== 1'b1) begin bad++; $display("FAIL exp_after got=e%b t%b want=e0 t1", tif.expired, tif.time_up); end
    pulse_start();
    wait_cyc(1);
    total++; if (tif.running !== 1'b0 || tif.expired !== 1'b0 || tif.time_up !== 1'b1 || digs() !== 12'h000) begin bad++; $display("FAIL done_start got=r%b e%b t%b %h want=r0 e0 t1 000", tif.running, tif.expired, tif.time_up, digs()); end
  endtask

  task automatic test_stop_on_tick();
    drive_load(4'd0, 4'd2, 4'd0, 1'b0);
    pulse_start();
    wait_cyc(3);
    pulse_stop();
    total++; if (tif.running !== 1'b0 || digs() !== 12'h020) begin bad++; $display("FAIL stop_tick got=r%b %h want=r0 020", tif.running, digs()); end
    wait_cyc(3);
    total++; if (digs() !== 12'h020) begin bad++; $display("FAIL stop_hold got=%h want=020", digs()); end
    pulse_start();
    wait_cyc(3);
    total++; if (digs() !== 12'h020 || tif.running !== 1'b1) begin bad++; $display("FAIL resume_pre got=r%b %h want=r1 020", tif.running, digs()); end
    wait_cyc(1);
    total++; if (digs() !== 12'h019) begin bad++; $display("FAIL resume_tick got=%h want=019", digs()); end
  endtask

  task automatic test_zero_clamp();
    drive_load(4'd0, 4'd0, 4'd0, 1'b0);
    pulse_start();
    total++; if (tif.expired !== 1'b1 || tif.time_up !== 1'b1 || tif.running !== 1'b0) begin bad++; $display("FAIL zero_start got=e%b t%b r%b want=e1 t1 r0", tif.expired, tif.time_up, tif.running); end
    wait_cyc(1);
    total++; if (tif.expired !== 1'b0) begin bad++; $display("FAIL zero_pulse got=%b want=0", tif.expired); end
    drive_load(4'd12, 4'd3, 4'd4, 1'b0);
    total++; if (digs() !== 12'h934 || tif.time_up !== 1'b0) begin bad++; $display("FAIL clamp got=%h t%b want=934 t0", digs(), tif.time_up); end
    drive_load(4'd0, 4'd0, 4'd5, 1'b1);
    total++; if (tif.running !== 1'b0 || digs() !== 12'h005) begin bad++; $display("FAIL load_start got=r%b %h want=r0 005", tif.running, digs()); end
    wait_cyc(5);
    total++; if (tif.running !== 1'b0 || digs() !== 12'h005) begin bad++; $display("FAIL load_start_idle got=r%b %h want=r0 005", tif.running, digs()); end
  endtask

  task automatic test_async_reset();
    drive_load(4'd0, 4'd3, 4'd0, 1'b0);
    pulse_start();
    wait_cyc(2);
    #2 reset = 1'b0;
    #1;
    total++; if (digs() !== 12'h200 || tif.running !== 1'b0) begin bad++; $display("FAIL async_reset got=r%b %h want=r0 200", tif.running, digs()); end
    @(negedge clk) reset = 1'b1;
    wait_cyc(2);
    total++; if (digs() !== 12'h200 || tif.running !== 1'b0) begin bad++; $display("FAIL post_reset got=r%b %h want=r0 200", tif.running, digs()); end
  endtask

`ifdef TIMER_WARN_EN
  task automatic test_warn();
    drive_load(4'd0, 4'd1, 4'd2, 1'b0);
    pulse_start();
    total++; if (tif.warn !== 1'b0) begin bad++; $display("FAIL warn_012 got=%b want=0", tif.warn); end
    wait_cyc(4);
    total++; if (tif.warn !== 1'b0 || digs() !== 12'h011) begin bad++; $display("FAIL warn_011 got=%b %h want=0 011", tif.warn, digs()); end
    wait_cyc(4);
    total++; if (tif.warn !== 1'b1 || digs() !== 12'h010) begin bad++; $display("FAIL warn_010 got=%b %h want=1 010", tif.warn, digs()); end
    pulse_stop();
    total++; if (tif.warn !== 1'b0 || digs() !== 12'h010) begin bad++; $display("FAIL warn_stop got=%b %h want=0 010", tif.warn, digs()); end
  endtask
`endif

  initial begin
    tif.load = 1'b0; tif.start = 1'b0; tif.stop = 1'b0;
    tif.load_three = 4'd0; tif.load_two = 4'd0; tif.load_one = 4'd0;
    test_reset();
    test_count();
    test_borrow();
    test_expire();
    test_stop_on_tick();
    test_zero_clamp();
    test_async_reset();
`ifdef TIMER_WARN_EN
    test_warn();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

- Three-digit BCD countdown timer for the bomb-defusal game.
- Loads the per-level time budget, one BCD digit per port, and counts it down once per second.
- Drives the three seven-segment digit decoders.
- Signals expiry to the game-control FSM, which decides whether the bomb detonates.

## Interface
Parameters:
- TICK_DIV, 50000000, clk cycles per one-second tick (≥2)
- WARN_SECS, 10, low-time threshold in seconds (0–99), used only when the warning feature is compiled in

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset; reset==0 clears the block
- load  input  1  one-cycle pulse: capture load_three/load_two/load_one as the new budget
- load_three  input  4  BCD hundreds digit of budget
- load_two  input  4  BCD tens digit
- load_one  input  4  BCD units digit
- start  input  1  one-cycle pulse: begin or resume counting
- stop  input  1  one-cycle pulse: freeze count (bomb defused / paused)
- digit_three  output  4  remaining time, hundreds
- digit_two  output  4  remaining time, tens
- digit_one  output  4  remaining time, units
- running  output  1  high while in RUN
- expired  output  1  one-cycle pulse on reaching 000
- time_up  output  1  level, high while in DONE
- warn  output  1  present only with TIMER_WARN_EN

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: digits 2,0,0 (the level-0 budget); running=0; expired=0; time_up=0; warn=0; prescaler=0.
- load, any state:
  - Digits take the load values; any digit >9 is clamped to 9.
  - Prescaler clears; state goes to IDLE; expired and time_up go low.
- start in IDLE:
  - If digits ≠ 000: go to RUN and clear the prescaler.
  - If digits = 000: go to DONE and pulse expired.
- start in RUN or DONE is ignored.
- stop in RUN goes to IDLE; digits hold and the prescaler clears. stop in any other state is ignored.
- Prescaler runs only in RUN. It counts 0..TICK_DIV-1; the cycle at TICK_DIV-1 is a tick and the prescaler wraps to 0.
- On a tick, decrement with BCD borrow:
  - units 0→9 borrows from tens; tens 0→9 borrows from hundreds.
  - Example: 100 → 099; 010 → 009.
- A tick that produces 000 moves the FSM to DONE in the same edge and pulses expired.
- DONE holds 000. Only load or reset leaves DONE.
- Simultaneous events, priority reset > load > stop > tick > start:
  - load together with start: start is ignored.
  - stop together with a tick: no decrement.

## Timing
- All outputs are registered and change on the clk rising edge after the input that causes them.
- load: new digits visible one cycle after the load pulse.
- start: running high one cycle after start. First decrement occurs TICK_DIV cycles after running rises; later decrements every TICK_DIV cycles.
- expired is high for exactly one cycle, coincident with the first cycle of time_up and digits=000.
- Reset is asynchronous. Asserting it mid-count forces reset values immediately. Deassertion takes effect at the next clk edge.

## Configuration
- TIMER_WARN_EN defined: warn is registered, and is high when state is RUN, digit_three=0, and the two-digit value 10·digit_two + digit_one ≤ WARN_SECS.
- TIMER_WARN_EN undefined: the warn port and its logic are absent; all other behaviour is identical.

## Structure
- Shared game package holds:
  - the FSM state typedef (IDLE/RUN/DONE)
  - the BCD digit typedef (4 bits)
  - the reset-budget constants 2,0,0, which the level-time table also uses
- One sub-module, bcd_digit_dec: single-digit decrementer.
  - Inputs: digit, borrow_in.
  - Outputs: digit_next, borrow_out.
  - Three instances are chained.
- Prescaler and FSM live in the top module.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then release: digits 200, running=0, time_up=0. Load 0,1,5 then start: decrements to 014 four cycles after running rises, then 013 four cycles later.
- Load 1,0,0, start, wait one tick: digits 099. Load 0,1,0, start, one tick: 009.
- Load 0,0,2, start: 001 then 000. expired is a single-cycle pulse coincident with the 000 digits; time_up stays high; a further start is ignored.
- Mid-count stop on the same cycle as a tick: no decrement, running=0, digits held. A later start resumes with a full TICK_DIV before the next decrement.
- Load 0,0,0 then start: DONE with one expired pulse. Load 12,3,4 (hundreds digit out of range): digits 934. Load and start on the same cycle: state IDLE.
- With TIMER_WARN_EN: load 0,1,2 and run. warn rises when the display reaches 010. stop drops warn to 0 while digits hold at their current value.
